// File: rtl/pipe_hazard_chain.sv
// Hazard/forwarding controller: shadows the post-decode pipeline as a tag chain
// and derives stalls, flushes, execute-stage bypass selects and event counters.
module pipe_hazard_chain #(
    parameter int  STAGES = 3,
    parameter int  ADDR_W = 5,
    parameter int  CNT_W  = 16,
    localparam int SEL_W  = $clog2(STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_valid,
    input  logic [ADDR_W-1:0]        d_rs1,
    input  logic [ADDR_W-1:0]        d_rs2,
    input  logic [ADDR_W-1:0]        d_rd,
    input  logic                     d_regwrite,
    input  logic                     d_load,
    input  logic                     br_taken,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     flush_d,
    output logic                     flush_e,
    output logic [SEL_W-1:0]         fwd_a,
    output logic [SEL_W-1:0]         fwd_b,
    output logic [STAGES-1:0]        slot_valid,
    output logic [STAGES*ADDR_W-1:0] slot_rd,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    logic              valid_reg    [STAGES];
    logic [ADDR_W-1:0] rd_reg       [STAGES];
    logic              regwrite_reg [STAGES];
    logic              load_reg     [STAGES];
    logic [ADDR_W-1:0] rs1_reg      [STAGES];
    logic [ADDR_W-1:0] rs2_reg      [STAGES];

    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;

    logic              slot0_load_producer;
    logic              load_use;
    logic [STAGES-1:0] hit_a;
    logic [STAGES-1:0] hit_b;

    // A load in execute whose result decode needs cannot be bypassed in time.
    assign slot0_load_producer = valid_reg[0] & load_reg[0] & regwrite_reg[0]
                               & (rd_reg[0] != '0);
    assign load_use = d_valid & slot0_load_producer
                    & ((rd_reg[0] == d_rs1) | (rd_reg[0] == d_rs2));

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (br_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hit_a[0] = 1'b0;
    assign hit_b[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_hit
            logic producer;
            assign producer  = valid_reg[gi] & regwrite_reg[gi] & (rd_reg[gi] != '0);
            assign hit_a[gi] = valid_reg[0] & producer & (rd_reg[gi] == rs1_reg[0]);
            assign hit_b[gi] = valid_reg[0] & producer & (rd_reg[gi] == rs2_reg[0]);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching slot is the last writer.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (hit_a[k]) fwd_a = SEL_W'(k);
            if (hit_b[k]) fwd_b = SEL_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            valid_reg[0]    <= 1'b0;
            rd_reg[0]       <= '0;
            regwrite_reg[0] <= 1'b0;
            load_reg[0]     <= 1'b0;
            rs1_reg[0]      <= '0;
            rs2_reg[0]      <= '0;
        end else begin
            valid_reg[0]    <= d_valid;
            rd_reg[0]       <= d_rd;
            regwrite_reg[0] <= d_regwrite & d_valid;
            load_reg[0]     <= d_load & d_valid;
            rs1_reg[0]      <= d_rs1;
            rs2_reg[0]      <= d_rs2;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi]    <= 1'b0;
                    rd_reg[gi]       <= '0;
                    regwrite_reg[gi] <= 1'b0;
                    load_reg[gi]     <= 1'b0;
                    rs1_reg[gi]      <= '0;
                    rs2_reg[gi]      <= '0;
                end else begin
                    valid_reg[gi]    <= valid_reg[gi-1];
                    rd_reg[gi]       <= rd_reg[gi-1];
                    regwrite_reg[gi] <= regwrite_reg[gi-1];
                    load_reg[gi]     <= load_reg[gi-1];
                    rs1_reg[gi]      <= rs1_reg[gi-1];
                    rs2_reg[gi]      <= rs2_reg[gi-1];
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_out
            assign slot_valid[gi]                 = valid_reg[gi];
            assign slot_rd[gi*ADDR_W +: ADDR_W]   = rd_reg[gi];
        end
    endgenerate

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (load_use && !br_taken && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (br_taken && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Bench for pipe_hazard_chain: a default instance and a STAGES=5/CNT_W=4 instance
// share one stimulus stream and are compared every cycle against an instruction-history model.
module tb_pipe_hazard_chain;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          d_valid = 1'b0, d_regwrite = 1'b0, d_load = 1'b0, br_taken = 1'b0;
    logic [AW-1:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;

    logic          a_stall_f, a_stall_d, a_flush_d, a_flush_e;
    logic [1:0]    a_fwd_a, a_fwd_b;
    logic [2:0]    a_slot_valid;
    logic [14:0]   a_slot_rd;
    logic [15:0]   a_stall_cnt, a_flush_cnt;

    logic          b_stall_f, b_stall_d, b_flush_d, b_flush_e;
    logic [2:0]    b_fwd_a, b_fwd_b;
    logic [4:0]    b_slot_valid;
    logic [24:0]   b_slot_rd;
    logic [3:0]    b_stall_cnt, b_flush_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_chain #(.STAGES(3), .ADDR_W(AW), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .d_regwrite(d_regwrite), .d_load(d_load), .br_taken(br_taken),
        .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d), .flush_e(a_flush_e),
        .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .slot_valid(a_slot_valid), .slot_rd(a_slot_rd),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_chain #(.STAGES(5), .ADDR_W(AW), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .d_regwrite(d_regwrite), .d_load(d_load), .br_taken(br_taken),
        .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d), .flush_e(b_flush_e),
        .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .slot_valid(b_slot_valid), .slot_rd(b_slot_rd),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // hist[k] is the instruction that entered execute k cycles ago (bubbles included).
    typedef struct {
        bit v; int rd; bit rw; bit ld; int rs1; int rs2;
    } ins_t;
    ins_t hist[8];
    int m_stall_a, m_flush_a, m_stall_b, m_flush_b;

    function automatic bit m_load_use();
        return d_valid && hist[0].v && hist[0].ld && hist[0].rw && hist[0].rd != 0 &&
               (hist[0].rd == int'(d_rs1) || hist[0].rd == int'(d_rs2));
    endfunction

    function automatic int m_fwd(input int src, input int depth);
        if (!hist[0].v) return 0;
        for (int k = 1; k < depth; k++)
            if (hist[k].v && hist[k].rw && hist[k].rd != 0 && hist[k].rd == src) return k;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    initial begin
        bit lu;
        bit e_sf, e_sd, e_fd, e_fe;
        logic [2:0]  ev_a;
        logic [14:0] er_a;
        logic [4:0]  ev_b;
        logic [24:0] er_b;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int k = 0; k < 8; k++) hist[k] = '{0, 0, 0, 0, 0, 0};
                m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
            end else begin
                lu = m_load_use();
                if (br_taken) begin
                    m_flush_a = sat_inc(m_flush_a, 65535);
                    m_flush_b = sat_inc(m_flush_b, 15);
                end else if (lu) begin
                    m_stall_a = sat_inc(m_stall_a, 65535);
                    m_stall_b = sat_inc(m_stall_b, 15);
                end
                for (int k = 7; k >= 1; k--) hist[k] = hist[k-1];
                if (br_taken || lu) hist[0] = '{0, 0, 0, 0, 0, 0};
                else hist[0] = '{d_valid, int'(d_rd), d_regwrite && d_valid,
                                 d_load && d_valid, int'(d_rs1), int'(d_rs2)};
            end
            @(negedge clk);
            lu = m_load_use();
            e_sf = !br_taken && lu;
            e_sd = e_sf;
            e_fd = br_taken;
            e_fe = br_taken || lu;
            for (int k = 0; k < 3; k++) begin
                ev_a[k] = hist[k].v;
                er_a[k*AW +: AW] = AW'(hist[k].rd);
            end
            for (int k = 0; k < 5; k++) begin
                ev_b[k] = hist[k].v;
                er_b[k*AW +: AW] = AW'(hist[k].rd);
            end
            chk("a_stall_f", 32'(a_stall_f), 32'(e_sf));
            chk("a_stall_d", 32'(a_stall_d), 32'(e_sd));
            chk("a_flush_d", 32'(a_flush_d), 32'(e_fd));
            chk("a_flush_e", 32'(a_flush_e), 32'(e_fe));
            chk("a_fwd_a", 32'(a_fwd_a), 32'(m_fwd(hist[0].rs1, 3)));
            chk("a_fwd_b", 32'(a_fwd_b), 32'(m_fwd(hist[0].rs2, 3)));
            chk("a_slot_valid", 32'(a_slot_valid), 32'(ev_a));
            chk("a_slot_rd", 32'(a_slot_rd), 32'(er_a));
            chk("a_stall_cnt", 32'(a_stall_cnt), 32'(m_stall_a));
            chk("a_flush_cnt", 32'(a_flush_cnt), 32'(m_flush_a));
            chk("b_stall_f", 32'(b_stall_f), 32'(e_sf));
            chk("b_flush_d", 32'(b_flush_d), 32'(e_fd));
            chk("b_flush_e", 32'(b_flush_e), 32'(e_fe));
            chk("b_fwd_a", 32'(b_fwd_a), 32'(m_fwd(hist[0].rs1, 5)));
            chk("b_fwd_b", 32'(b_fwd_b), 32'(m_fwd(hist[0].rs2, 5)));
            chk("b_slot_valid", 32'(b_slot_valid), 32'(ev_b));
            chk("b_slot_rd", 32'(b_slot_rd), 32'(er_b));
            chk("b_stall_cnt", 32'(b_stall_cnt), 32'(m_stall_b));
            chk("b_flush_cnt", 32'(b_flush_cnt), 32'(m_flush_b));
            // The load-use bubble must keep a load in slot 1 from ever feeding slot 0.
            if (hist[0].v && hist[1].v && hist[1].ld && hist[1].rw && hist[1].rd != 0 &&
                (hist[1].rd == hist[0].rs1 || hist[1].rd == hist[0].rs2)) begin
                total_cnt++;
                $display("FAIL load_in_slot1_match: load rd=%0d feeds slot 0 at %0t",
                         hist[1].rd, $time);
            end
        end
    end

    task automatic drive(input bit v, input int rd, input int rs1, input int rs2,
                         input bit rw, input bit ld, input bit br);
        @(posedge clk);
        #1;
        d_valid = v; d_rd = AW'(rd); d_rs1 = AW'(rs1); d_rs2 = AW'(rs2);
        d_regwrite = rw; d_load = ld; br_taken = br;
        $display("txn %0t: v=%0b rd=%0d rs1=%0d rs2=%0d rw=%0b ld=%0b br=%0b",
                 $time, v, rd, rs1, rs2, rw, ld, br);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rst();
        @(posedge clk);
        #1;
        reset = 1'b1;
        d_valid = 0; d_rd = '0; d_rs1 = '0; d_rs2 = '0;
        d_regwrite = 0; d_load = 0; br_taken = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("txn %0t: reset", $time);
        @(negedge clk);
    endtask

    initial begin
        rst();
        idle(2);
        chk("lit_reset_slot_valid", 32'(a_slot_valid), 32'd0);
        chk("lit_reset_fwd", 32'({a_fwd_a, a_fwd_b}), 32'd0);
        chk("lit_reset_cnt", 32'({a_stall_cnt, a_flush_cnt}), 32'd0);
        chk("lit_reset_hazard", 32'({a_stall_f, a_stall_d, a_flush_d, a_flush_e}), 32'd0);

        // add x5 ; sub x6,x5,x5 ; unrelated
        drive(1, 5, 1, 2, 1, 0, 0);
        drive(1, 6, 5, 5, 1, 0, 0);
        drive(1, 8, 3, 4, 1, 0, 0);
        chk("lit_sub_fwd_a", 32'(a_fwd_a), 32'd1);
        chk("lit_sub_fwd_b", 32'(a_fwd_b), 32'd1);
        idle(1);
        chk("lit_unrelated_fwd_a", 32'(a_fwd_a), 32'd0);

        // two writers of x5: youngest wins
        drive(1, 5, 0, 0, 1, 0, 0);
        drive(1, 5, 0, 0, 1, 0, 0);
        drive(1, 11, 5, 0, 1, 0, 0);
        idle(1);
        chk("lit_youngest_wins", 32'(a_fwd_a), 32'd1);
        idle(3);

        // lw x7 ; add rs1=7 -> one stall cycle, then forward from slot 2
        drive(1, 7, 1, 2, 1, 1, 0);
        drive(1, 9, 7, 3, 1, 0, 0);
        chk("lit_lu_hazard", 32'({a_stall_f, a_stall_d, a_flush_d, a_flush_e}), 32'b1101);
        drive(1, 9, 7, 3, 1, 0, 0);
        chk("lit_lu_bubble", 32'(a_slot_valid[0]), 32'd0);
        chk("lit_lu_stall_cnt", 32'(a_stall_cnt), 32'd1);
        idle(1);
        chk("lit_lu_fwd_a", 32'(a_fwd_a), 32'd2);
        chk("lit_lu_fwd_a_b", 32'(b_fwd_a), 32'd2);

        // reset with work in flight
        drive(1, 3, 0, 0, 1, 0, 0);
        idle(1);
        rst();
        chk("lit_midreset_valid_a", 32'(a_slot_valid), 32'd0);
        chk("lit_midreset_valid_b", 32'(b_slot_valid), 32'd0);

        // lw x7 in execute, dependent in decode, branch wins
        drive(1, 7, 1, 2, 1, 1, 0);
        drive(1, 9, 7, 7, 1, 0, 1);
        chk("lit_br_hazard", 32'({a_stall_f, a_stall_d, a_flush_d, a_flush_e}), 32'b0011);
        idle(1);
        chk("lit_br_flush_cnt", 32'(a_flush_cnt), 32'd1);
        chk("lit_br_stall_cnt", 32'(a_stall_cnt), 32'd0);

        // writes to x0 never forward; load to x0 never stalls
        drive(1, 0, 1, 1, 1, 0, 0);
        drive(1, 10, 0, 0, 1, 0, 0);
        idle(1);
        chk("lit_x0_fwd", 32'({a_fwd_a, a_fwd_b}), 32'd0);
        drive(1, 0, 1, 1, 1, 1, 0);
        drive(1, 10, 0, 0, 1, 0, 0);
        chk("lit_x0_load_nostall", 32'({a_stall_f, a_flush_e}), 32'd0);
        idle(3);

        // 20 load-use events: 4-bit counter sticks at 15
        for (int i = 0; i < 20; i++) begin
            drive(1, 7, 1, 2, 1, 1, 0);
            drive(1, 9, 7, 7, 1, 0, 0);
        end
        idle(1);
        chk("lit_sat_b", 32'(b_stall_cnt), 32'd15);
        chk("lit_sat_a", 32'(a_stall_cnt), 32'd20);
        idle(5);

        // only match sits in slot 4 of the deep instance
        drive(1, 12, 0, 0, 1, 0, 0);
        idle(3);
        drive(1, 13, 12, 0, 1, 0, 0);
        idle(1);
        chk("lit_slot4_fwd_b_inst", 32'(b_fwd_a), 32'd4);
        chk("lit_slot4_fwd_a_inst", 32'(a_fwd_a), 32'd0);

        // mixed traffic over a small register set
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0));
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_chain.md
Name: pipe_hazard_chain

Overview:
- Parametrised hazard and forwarding controller for the N-stage integer pipeline, fed from the decode stage.
- Keeps its own tag chain of STAGES slots. Slot 0 is execute; slot STAGES-1 is writeback.
- Each slot holds valid, rd, regwrite, load, rs1 and rs2.
- From the chain it generates fetch/decode stalls, decode/execute flushes, per-operand forwarding selects for the execute stage, and saturating stall/flush event counters.

Parameters:
- STAGES, 3, number of slots after decode (E, M, W by default); legal range 3..8.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the event counters.
- SEL_W, $clog2(STAGES), width of the forwarding selects (derived; not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- d_valid  in  1  decode holds a real instruction
- d_rs1  in  ADDR_W  decode source register 1
- d_rs2  in  ADDR_W  decode source register 2
- d_rd  in  ADDR_W  decode destination register
- d_regwrite  in  1  decode instruction writes rd
- d_load  in  1  decode instruction is a load
- br_taken  in  1  execute-stage branch/jump redirect this cycle
- stall_f  out  1  hold PC
- stall_d  out  1  hold the F/D register
- flush_d  out  1  clear the F/D register
- flush_e  out  1  clear the D/E register (bubble into slot 0)
- fwd_a  out  SEL_W  operand-A source for slot 0: 0 = register file, k = result of slot k
- fwd_b  out  SEL_W  operand-B source for slot 0, same encoding as fwd_a
- slot_valid  out  STAGES  valid bit per slot; bit k = slot k
- slot_rd  out  STAGES*ADDR_W  rd per slot; slot k in bits [k*ADDR_W +: ADDR_W]
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect cycles

Behaviour:
Reset:
- Synchronous on clk rising edge while reset=1.
- All slots become invalid with fields zeroed; stall_cnt = flush_cnt = 0.
- Combinational outputs then read: stall_f = stall_d = flush_d = flush_e = 0, fwd_a = fwd_b = 0.
- Reset asserted mid-operation discards all in-flight tags in the same edge.

Hazard detect (combinational):
- load_use = d_valid & slot0.valid & slot0.load & slot0.regwrite & (slot0.rd != 0) & (slot0.rd == d_rs1 | slot0.rd == d_rs2).
- Priority: br_taken beats load_use.
  - br_taken=1: stall_f=0, stall_d=0, flush_d=1, flush_e=1.
  - else load_use=1: stall_f=1, stall_d=1, flush_d=0, flush_e=1.
  - else: all four are 0.

Chain advance (every clock; slots 1..STAGES-1 never stall):
- Slot k+1 takes slot k.
- If flush_e=1, slot 0 takes a bubble (valid=0, all fields 0).
- Otherwise slot 0 takes {d_valid, d_rd, d_regwrite & d_valid, d_load & d_valid, d_rs1, d_rs2}.
- Slot STAGES-1 contents drop off the end; the regfile is write-first, so no hazard exists beyond the chain.

Forwarding (combinational, for the operands of slot 0):
- fwd_a = smallest k in 1..STAGES-1 with slot k valid & regwrite & rd != 0 & rd == slot0.rs1; 0 if no such k.
- fwd_b: same rule against slot0.rs2.
- Youngest (smallest k) match wins when several slots match.
- fwd_a = fwd_b = 0 whenever slot0.valid = 0.
- A load in slot 1 is never a match for a valid consumer in slot 0; the one-cycle bubble guarantees this, and the bench asserts it.

Counters:
- stall_cnt increments on cycles with load_use & ~br_taken.
- flush_cnt increments on cycles with br_taken.
- Both saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset, then idle with d_valid=0 -> all slot_valid=0, fwd_a=fwd_b=0, counters 0, all stall/flush outputs 0.
- add x5 (rd=5), then sub with rs1=5, rs2=5 -> sub's cycle in slot 0: fwd_a=1, fwd_b=1. One cycle later, with an unrelated instruction in slot 0: fwd_a=0.
- lw x7 then add rs1=7 -> one cycle with stall_f=stall_d=flush_e=1 and a bubble in slot 0. Add then enters slot 0 with fwd_a=2. stall_cnt=1.
- lw x7 in slot 0, dependent in decode, and br_taken=1 in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt=1, stall_cnt=0.
- Writes to x0 (rd=0, regwrite=1) followed by a consumer with rs1=0 -> fwd_a=0; a load to x0 causes no stall.
- Counter saturation, CNT_W=4: 20 consecutive load-use cycles -> stall_cnt holds 15. Separately, a STAGES=5 run with a match only in slot 4 -> fwd_a=4.
